pds_pkt_collector: RTL and testbench
====================================

PDS_PKT_COLLECTOR -- requirements
Module: pds_pkt_collector

Interface
REQ-001 Parameter: DEPTH, 32, FIFO depth in bytes; power of two; at least MAX_LEN+1.
REQ-002 Parameter: MAX_LEN, 16, largest legal payload length in bytes; range 1..63.
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_data  input  8  byte stream from the DUT out_data.
REQ-006 Port: in_valid  input  1  byte qualifier from the DUT out_valid; no backpressure upstream.
REQ-007 Port: out_data  output  8  packet byte to the consumer.
REQ-008 Port: out_valid  output  1  out_data holds a valid committed byte.
REQ-009 Port: out_ready  input  1  consumer accepts the byte; a transfer occurs when out_valid and out_ready are both 1.
REQ-010 Port: out_sop  output  1  current out_data is a header byte.
REQ-011 Port: out_eop  output  1  current out_data is the last payload byte.
REQ-012 Port: pkt_err  output  1  one-cycle pulse on a bad header or a bad checksum.
REQ-013 Port: drop_cnt  output  8  count of dropped packets; saturates at 255.

Function
REQ-014 Packet format: header byte first; bits [7:6] are the destination port and bits [5:0] are the payload length L. L payload bytes follow, then one checksum byte when the checksum feature is enabled.
REQ-015 Input FSM states: IDLE, PAYLOAD, CHECK and SKIP. Only in_valid cycles advance the FSM.
REQ-016 IDLE with a valid byte: if L = 0 or L > MAX_LEN, pulse pkt_err on the next cycle, discard the byte and stay in IDLE.
REQ-017 IDLE with a legal header: if free space is at least L+1, write the header to the FIFO at the speculative write pointer and go to PAYLOAD. Otherwise go to SKIP and increment drop_cnt.
REQ-018 PAYLOAD: write each byte and accumulate the XOR of header and payload. After the L-th byte, go to CHECK.
REQ-019 CHECK with a valid byte: if the byte equals the XOR, commit by copying the speculative write pointer to the committed pointer on the same edge. If it does not match, roll the speculative pointer back to the committed pointer, pulse pkt_err and increment drop_cnt. In both cases go to IDLE.
REQ-020 SKIP: consume and discard the remaining L payload bytes plus the checksum byte (when enabled), then go to IDLE. Nothing is written.
REQ-021 The output side sees only committed bytes. out_valid rises the cycle after the commit edge. An empty committed region gives out_valid = 0.
REQ-022 The output side parses the header at the FIFO head to count payload bytes. out_sop is asserted with the header byte and out_eop with the L-th payload byte.
REQ-023 out_data, out_sop and out_eop hold stable while out_valid = 1 and out_ready = 0.
REQ-024 A commit and an output read on the same edge both take effect. Free space is computed from the read pointer before that edge.
REQ-025 Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full means the pointers are equal except for the MSB.
REQ-026 Sustained throughput is one byte per cycle on both input and output.

Reset
REQ-027 When rst_n = 0: FSM goes to IDLE; all pointers and the XOR accumulator clear; drop_cnt = 0; out_valid, out_sop, out_eop, pkt_err and out_data = 0.
REQ-028 Reset asserted mid-packet discards all buffered and partial data. The first valid byte after deassertion is treated as a header.

Configuration
REQ-029 Macro PDS_PKT_CHKSUM_EN defined: the checksum byte is expected and checked, and the CHECK state exists.
REQ-030 Macro PDS_PKT_CHKSUM_EN undefined: no checksum byte is expected and the CHECK state does not exist. The commit happens on the edge that writes the L-th payload byte. pkt_err fires only for illegal headers.

Verification
REQ-031 Checksum enabled; input 0x43, 0x11, 0x22, 0x33, checksum 0x43^0x11^0x22^0x33 = 0x43; out_ready = 1 -> out_valid rises the cycle after the commit. Output bytes are 0x43 with out_sop, 0x11, 0x22, then 0x33 with out_eop.
REQ-032 Same packet with a checksum byte of 0x00 -> pkt_err pulses for one cycle, drop_cnt = 1 and out_valid stays 0.
REQ-033 Header 0x00, then header 0x3F with MAX_LEN = 16 -> two pkt_err pulses, drop_cnt is unchanged and the FSM is in IDLE.
REQ-034 DEPTH = 32 with out_ready = 0; send three packets with L = 10 -> the first two are stored (22 bytes). The third goes to SKIP and drop_cnt = 1. Raising out_ready drains exactly 22 bytes with correct SOP/EOP framing.
REQ-035 out_ready toggles every cycle during drain -> no byte is lost or duplicated and outputs hold stable while stalled.
REQ-036 rst_n pulsed low after 2 payload bytes of a packet with L = 5 -> all outputs are 0. A following legal packet is received intact.

Source files
------------

// File: rtl/pds_pkt_collector_if.sv
// Byte-stream and packet-output bundle for pds_pkt_collector.
// slave = the collector, master = the upstream producer / downstream consumer.
interface pds_pkt_collector_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sop;
    logic       out_eop;
    logic       pkt_err;
    logic [7:0] drop_cnt;

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_sop, out_eop, pkt_err, drop_cnt
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_sop, out_eop, pkt_err, drop_cnt
    );
endinterface

// File: rtl/pds_pkt_collector.sv
// Packet collector: speculatively buffers header+payload, commits whole packets only.
// Optional checksum trailer enabled by defining PDS_PKT_CHKSUM_EN.
module pds_pkt_collector #(
    parameter int DEPTH   = 32,
    parameter int MAX_LEN = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pds_pkt_collector_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 3;
    localparam logic [6:0] MAX_L = 7'(MAX_LEN);

`ifdef PDS_PKT_CHKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_SKIP} state_t;
    localparam logic [6:0] TRAILER = 7'd1;
`else
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_SKIP} state_t;
    localparam logic [6:0] TRAILER = 7'd0;
`endif

    state_t        state_q;
    logic [6:0]    cnt_q;
    logic [PW-1:0] wr_spec_q, wr_com_q, rd_q;
    logic          pkt_err_q;
    logic [7:0]    drop_q;
    logic [5:0]    ocnt_q;
    logic [7:0]    mem_q [DEPTH];
`ifdef PDS_PKT_CHKSUM_EN
    logic [7:0]    xor_q;
`endif

    logic [5:0]    hdr_len;
    logic          hdr_bad;
    logic [PW-1:0] used;
    logic [CW-1:0] need;
    logic          fits;
    logic          wr_en;
    logic [7:0]    drop_inc;
    logic          avail;
    logic          xfer;
    logic [7:0]    head;

    assign hdr_len  = bus.in_data[5:0];
    assign hdr_bad  = (hdr_len == 6'd0) || ({1'b0, hdr_len} > MAX_L);
    // Space check uses the read pointer as it stood before this edge.
    assign used     = wr_spec_q - rd_q;
    assign need     = CW'(used) + CW'(hdr_len) + CW'(1);
    assign fits     = need <= CW'(DEPTH);
    assign drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    assign wr_en    = bus.in_valid &&
                      (((state_q == S_IDLE) && !hdr_bad && fits) || (state_q == S_PAYLOAD));

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_spec_q[AW-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_spec_q <= '0;
            wr_com_q  <= '0;
            pkt_err_q <= 1'b0;
            drop_q    <= '0;
`ifdef PDS_PKT_CHKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            pkt_err_q <= 1'b0;
            if (bus.in_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (hdr_bad) begin
                            pkt_err_q <= 1'b1;
                        end else if (fits) begin
                            wr_spec_q <= wr_spec_q + PW'(1);
                            cnt_q     <= {1'b0, hdr_len};
                            state_q   <= S_PAYLOAD;
`ifdef PDS_PKT_CHKSUM_EN
                            xor_q     <= bus.in_data;
`endif
                        end else begin
                            drop_q  <= drop_inc;
                            cnt_q   <= {1'b0, hdr_len} + TRAILER;
                            state_q <= S_SKIP;
                        end
                    end
                    S_PAYLOAD: begin
                        wr_spec_q <= wr_spec_q + PW'(1);
                        cnt_q     <= cnt_q - 7'd1;
`ifdef PDS_PKT_CHKSUM_EN
                        xor_q     <= xor_q ^ bus.in_data;
                        if (cnt_q == 7'd1) state_q <= S_CHECK;
`else
                        // No trailer: the last payload write is also the commit.
                        if (cnt_q == 7'd1) begin
                            wr_com_q <= wr_spec_q + PW'(1);
                            state_q  <= S_IDLE;
                        end
`endif
                    end
`ifdef PDS_PKT_CHKSUM_EN
                    S_CHECK: begin
                        state_q <= S_IDLE;
                        if (bus.in_data == xor_q) begin
                            wr_com_q <= wr_spec_q;
                        end else begin
                            wr_spec_q <= wr_com_q;
                            pkt_err_q <= 1'b1;
                            drop_q    <= drop_inc;
                        end
                    end
`endif
                    S_SKIP: begin
                        cnt_q <= cnt_q - 7'd1;
                        if (cnt_q == 7'd1) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Output side walks only the committed region; ocnt_q = payload bytes left, 0 = at header.
    assign avail = (wr_com_q != rd_q);
    assign head  = mem_q[rd_q[AW-1:0]];
    assign xfer  = avail && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            ocnt_q <= '0;
        end else if (xfer) begin
            rd_q   <= rd_q + PW'(1);
            ocnt_q <= (ocnt_q == 6'd0) ? head[5:0] : ocnt_q - 6'd1;
        end
    end

    assign bus.out_valid = avail;
    assign bus.out_data  = avail ? head : 8'h00;
    assign bus.out_sop   = avail && (ocnt_q == 6'd0);
    assign bus.out_eop   = avail && (ocnt_q == 6'd1);
    assign bus.pkt_err   = pkt_err_q;
    assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_pds_pkt_collector.sv
// Scoreboard bench for pds_pkt_collector; covers both PDS_PKT_CHKSUM_EN builds.
module tb_pds_pkt_collector;
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   exp_drop = 0;
    beat_t exp_q[$];

    pds_pkt_collector_if bus ();

    pds_pkt_collector #(.DEPTH(32), .MAX_LEN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base,
                            input logic [7:0] step, input bit bad_chk);
        logic [7:0] x;
        logic [7:0] b;
        x = hdr;
        drive(hdr);
        for (int i = 0; i < int'(hdr[5:0]); i++) begin
            b = base + 8'(i) * step;
            x ^= b;
            drive(b);
        end
        x = bad_chk ? 8'h00 : x;
`ifdef PDS_PKT_CHKSUM_EN
        drive(x);
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_pkt(input logic [7:0] hdr, input logic [7:0] base, input logic [7:0] step);
        int l;
        l = int'(hdr[5:0]);
        exp_q.push_back(beat_t'{sop: 1'b1, eop: 1'b0, d: hdr});
        for (int i = 0; i < l; i++)
            exp_q.push_back(beat_t'{sop: 1'b0, eop: (i == l - 1), d: base + 8'(i) * step});
    endtask

    task automatic wait_drain(input string nm, input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_valid_low"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
    initial begin
        beat_t prev, cur, e;
        bit    stall_prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = beat_t'{sop: bus.out_sop, eop: bus.out_eop, d: bus.out_data};
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (bus.pkt_err) err_seen++;
                if (stall_prev) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_beat", 32'(cur), 32'(prev));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h expected none at %0t", cur, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", 32'(cur), 32'(e));
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                prev = cur;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_sop_eop", 32'({bus.out_sop, bus.out_eop}), 0);
        chk("rst_pkt_err", 32'(bus.pkt_err), 0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 0);
        rst_n = 1'b1;
        idle(2);

        // Basic packet: out_valid must appear right after the commit edge.
        bus.out_ready = 1'b1;
        expect_pkt(8'h43, 8'h11, 8'h11);
        drive(8'h43); drive(8'h11); drive(8'h22);
`ifdef PDS_PKT_CHKSUM_EN
        drive(8'h33);
        chk("t1_pre_commit", 32'(bus.out_valid), 0);
        drive(8'h43);
`else
        chk("t1_pre_commit", 32'(bus.out_valid), 0);
        drive(8'h33);
`endif
        bus.in_valid = 1'b0;
        chk("t1_post_commit", 32'(bus.out_valid), 1);
        wait_drain("t1", 50);

`ifdef PDS_PKT_CHKSUM_EN
        // Bad checksum: rolled back, dropped, one error pulse.
        send_pkt(8'h43, 8'h11, 8'h11, 1'b1);
        exp_err++;
        exp_drop++;
        idle(3);
        chk("t2_err_pulses", 32'(err_seen), 32'(exp_err));
        chk("t2_drop", 32'(bus.drop_cnt), 32'(exp_drop));
        chk("t2_no_output", 32'(bus.out_valid), 0);
`endif

        // Illegal headers (L=0, L=63, L=17) then a max-length legal packet.
        drive(8'h00); drive(8'h3F); drive(8'h11);
        exp_err += 3;
        idle(2);
        chk("t3_err_pulses", 32'(err_seen), 32'(exp_err));
        chk("t3_drop", 32'(bus.drop_cnt), 32'(exp_drop));
        expect_pkt(8'hD0, 8'hA0, 8'h03);
        send_pkt(8'hD0, 8'hA0, 8'h03, 1'b0);
        wait_drain("t3", 80);

        // Fill: two L=10 packets fit (22 bytes), third is skipped.
        bus.out_ready = 1'b0;
        expect_pkt(8'h0A, 8'h01, 8'h01);
        send_pkt(8'h0A, 8'h01, 8'h01, 1'b0);
        expect_pkt(8'h4A, 8'h30, 8'h05);
        send_pkt(8'h4A, 8'h30, 8'h05, 1'b0);
        send_pkt(8'h8A, 8'hF0, 8'h01, 1'b0);
        exp_drop++;
        // A legal packet after the skip must land in IDLE, not in stale skip state.
        idle(2);
        chk("t4_drop", 32'(bus.drop_cnt), 32'(exp_drop));
        chk("t4_stored_valid", 32'(bus.out_valid), 1);
        chk("t4_queue_len", 32'(exp_q.size()), 32'd22);
        bus.out_ready = 1'b1;
        wait_drain("t4", 80);

        // Toggle out_ready every cycle during drain.
        bus.out_ready = 1'b0;
        expect_pkt(8'h03, 8'h55, 8'h11);
        send_pkt(8'h03, 8'h55, 8'h11, 1'b0);
        expect_pkt(8'hC2, 8'h9A, 8'h0F);
        send_pkt(8'hC2, 8'h9A, 8'h0F, 1'b0);
        for (int i = 0; i < 30; i++) begin
            bus.out_ready = ~bus.out_ready;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_drain("t5", 40);
        chk("t5_err_total", 32'(err_seen), 32'(exp_err));

        // Reset mid-packet, then a fresh packet.
        drive(8'h05); drive(8'h01); drive(8'h02);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        chk("t6_rst_valid", 32'(bus.out_valid), 0);
        chk("t6_rst_data", 32'(bus.out_data), 0);
        chk("t6_rst_flags", 32'({bus.out_sop, bus.out_eop, bus.pkt_err}), 0);
        chk("t6_rst_drop", 32'(bus.drop_cnt), 32'(exp_drop));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        expect_pkt(8'h82, 8'hAA, 8'h11);
        send_pkt(8'h82, 8'hAA, 8'h11, 1'b0);
        wait_drain("t6", 40);
        chk("t6_drop_after", 32'(bus.drop_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
